// File: rtl/cordic_fixedpoint_result_fifo.sv
// Result FIFO between the CORDIC rotation control and the result consumer.
// First-word-fall-through: the head word sits in a registered output stage;
// words behind it live in a small RAM. Capacity counts both.
//
// Ports:
//   iClk, iReset_n      clock, synchronous active-low reset
//   iWrite_request      push request; accepted when oFull is low
//   iData               word to push ({x[31:0], y[31:0]})
//   oData, oData_valid  head-of-queue word and its valid flag
//   iData_ready         consumer takes oData this cycle
//   oAlmost_full        occupancy >= AF_THRESHOLD
//   oFull, oEmpty       occupancy == DEPTH / occupancy == 0
//   oCount              current occupancy
//   oOverflow           sticky: a write was dropped while full
module cordic_fixedpoint_result_fifo #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AF_THRESHOLD = 12
) (
  input  logic                      iClk,
  input  logic                      iReset_n,
  input  logic                      iWrite_request,
  input  logic [DATA_WIDTH-1:0]     iData,
  output logic [DATA_WIDTH-1:0]     oData,
  output logic                      oData_valid,
  input  logic                      iData_ready,
  output logic                      oAlmost_full,
  output logic                      oFull,
  output logic                      oEmpty,
  output logic [$clog2(DEPTH):0]    oCount,
  output logic                      oOverflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wrPtr;
  logic [PW-1:0]         rdPtr;

  logic          push_c;
  logic          pop_c;
  logic          loadOut_c;
  logic          memRead_c;
  logic          bypass_c;
  logic          memWrite_c;
  logic [CW-1:0] memCount_c;
  logic [CW-1:0] countNext_c;

  // Push/pop decode and output-stage refill selection
  always_comb begin
    push_c      = iWrite_request && !oFull;
    pop_c       = oData_valid && iData_ready;
    memCount_c  = oCount - CW'(oData_valid);
    // Output stage can take a new word when empty or being consumed
    loadOut_c   = !oData_valid || pop_c;
    memRead_c   = loadOut_c && (memCount_c != '0);
    // With nothing stored, a push goes straight into the output stage
    bypass_c    = loadOut_c && (memCount_c == '0) && push_c;
    memWrite_c  = push_c && !bypass_c;
    countNext_c = oCount + CW'(push_c) - CW'(pop_c);
  end

  // Storage RAM; contents are not reset
  always_ff @(posedge iClk) begin
    if (memWrite_c) begin
      mem[wrPtr] <= iData;
    end
  end

  // Pointers, output stage, occupancy and flags
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      oData        <= '0;
      oData_valid  <= 1'b0;
      oCount       <= '0;
      oEmpty       <= 1'b1;
      oFull        <= 1'b0;
      oAlmost_full <= 1'b0;
      oOverflow    <= 1'b0;
    end else begin
      if (memWrite_c) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (memRead_c) begin
        rdPtr <= rdPtr + PW'(1);
      end

      if (memRead_c) begin
        oData       <= mem[rdPtr];
        oData_valid <= 1'b1;
      end else if (bypass_c) begin
        oData       <= iData;
        oData_valid <= 1'b1;
      end else if (pop_c) begin
        oData_valid <= 1'b0;
      end

      oCount       <= countNext_c;
      oEmpty       <= (countNext_c == '0);
      oFull        <= (countNext_c == CW'(DEPTH));
      oAlmost_full <= (countNext_c >= CW'(AF_THRESHOLD));

      // Dropped write while full, even if a pop frees space this cycle
      if (iWrite_request && oFull) begin
        oOverflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cordic_fixedpoint_result_fifo.sv
// Directed and randomized checks of the CORDIC result FIFO.
module tb_cordic_fixedpoint_result_fifo;

  logic        iClk;
  logic        iReset_n;
  logic        iWrite_request;
  logic [63:0] iData;
  logic [63:0] oData;
  logic        oData_valid;
  logic        iData_ready;
  logic        oAlmost_full;
  logic        oFull;
  logic        oEmpty;
  logic [4:0]  oCount;
  logic        oOverflow;

  int checkCount;
  int errorCount;

  cordic_fixedpoint_result_fifo #(
    .DATA_WIDTH(64), .DEPTH(16), .AF_THRESHOLD(12)
  ) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iWrite_request(iWrite_request),
    .iData(iData), .oData(oData), .oData_valid(oData_valid),
    .iData_ready(iData_ready), .oAlmost_full(oAlmost_full), .oFull(oFull),
    .oEmpty(oEmpty), .oCount(oCount), .oOverflow(oOverflow)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkValue(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic doReset();
    iReset_n = 1'b0;
    tick();
    iReset_n = 1'b1;
    iWrite_request = 1'b0;
    iData_ready = 1'b0;
  endtask

  logic [63:0] sb[$];
  logic [63:0] exp;
  logic [63:0] word;
  int pushes;
  int cycles;
  logic wr;
  logic rd;

  initial begin
    checkCount = 0;
    errorCount = 0;
    iReset_n = 1'b0;
    iWrite_request = 1'b0;
    iData = '0;
    iData_ready = 1'b0;
    tick();
    tick();
    iReset_n = 1'b1;

    // Reset state
    checkValue("rst_valid", 64'(oData_valid), 64'd0);
    checkValue("rst_empty", 64'(oEmpty), 64'd1);
    checkValue("rst_full", 64'(oFull), 64'd0);
    checkValue("rst_af", 64'(oAlmost_full), 64'd0);
    checkValue("rst_count", 64'(oCount), 64'd0);
    checkValue("rst_ovf", 64'(oOverflow), 64'd0);
    checkValue("rst_data", oData, 64'd0);

    // Ready while empty does nothing
    iData_ready = 1'b1;
    tick();
    checkValue("underflow_count", 64'(oCount), 64'd0);
    checkValue("underflow_valid", 64'(oData_valid), 64'd0);
    iData_ready = 1'b0;

    // Single-word latency and hold
    iWrite_request = 1'b1;
    iData = 64'h0000_0001_0000_0002;
    tick();
    iWrite_request = 1'b0;
    iData = '0;
    checkValue("lat_valid", 64'(oData_valid), 64'd1);
    checkValue("lat_data", oData, 64'h0000_0001_0000_0002);
    checkValue("lat_count", 64'(oCount), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkValue("hold_data", oData, 64'h0000_0001_0000_0002);
      checkValue("hold_valid", 64'(oData_valid), 64'd1);
    end
    iData_ready = 1'b1;
    tick();
    iData_ready = 1'b0;
    checkValue("single_pop_valid", 64'(oData_valid), 64'd0);
    checkValue("single_pop_empty", 64'(oEmpty), 64'd1);

    // Fill to full, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      iWrite_request = 1'b1;
      iData = 64'(i);
      tick();
      checkValue("fill_count", 64'(oCount), 64'(i + 1));
      checkValue("fill_af", 64'(oAlmost_full), 64'((i + 1) >= 12));
      checkValue("fill_full", 64'(oFull), 64'((i + 1) == 16));
    end
    iData = 64'd99;
    tick();
    iWrite_request = 1'b0;
    checkValue("ovf_flag", 64'(oOverflow), 64'd1);
    checkValue("ovf_count", 64'(oCount), 64'd16);
    iData_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkValue("drain_valid", 64'(oData_valid), 64'd1);
      checkValue("drain_data", oData, 64'(i));
      tick();
    end
    iData_ready = 1'b0;
    checkValue("drain_empty", 64'(oEmpty), 64'd1);
    checkValue("ovf_sticky", 64'(oOverflow), 64'd1);
    doReset();
    checkValue("ovf_cleared", 64'(oOverflow), 64'd0);

    // Streaming through the bypass path, no bubbles
    iData_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      iWrite_request = 1'b1;
      iData = 64'(i + 100);
      tick();
      checkValue("stream_valid", 64'(oData_valid), 64'd1);
      checkValue("stream_data", oData, 64'(i + 100));
      checkValue("stream_count_le1", 64'(oCount <= 5'd1), 64'd1);
    end
    iWrite_request = 1'b0;
    tick();
    checkValue("stream_end_valid", 64'(oData_valid), 64'd0);
    iData_ready = 1'b0;

    // Simultaneous push/pop at count 8
    for (int i = 0; i < 8; i++) begin
      iWrite_request = 1'b1;
      iData = 64'(200 + i);
      tick();
    end
    checkValue("c8_count", 64'(oCount), 64'd8);
    iData = 64'd208;
    iData_ready = 1'b1;
    tick();
    iWrite_request = 1'b0;
    checkValue("c8_simul_count", 64'(oCount), 64'd8);
    for (int i = 0; i < 8; i++) begin
      checkValue("c8_order", oData, 64'(201 + i));
      tick();
    end
    iData_ready = 1'b0;
    checkValue("c8_empty", 64'(oEmpty), 64'd1);

    // Push and pop at full: push dropped
    for (int i = 0; i < 16; i++) begin
      iWrite_request = 1'b1;
      iData = 64'(300 + i);
      tick();
    end
    checkValue("full2_full", 64'(oFull), 64'd1);
    iData = 64'd999;
    iData_ready = 1'b1;
    tick();
    iWrite_request = 1'b0;
    iData_ready = 1'b0;
    checkValue("full_simul_count", 64'(oCount), 64'd15);
    checkValue("full_simul_ovf", 64'(oOverflow), 64'd1);
    checkValue("full_simul_head", oData, 64'd301);
    doReset();

    // Random backpressure against a scoreboard
    pushes = 0;
    cycles = 0;
    while (pushes < 1000 && cycles < 20000) begin
      wr = 1'($urandom_range(0, 1)) && !oFull;
      rd = 1'($urandom_range(0, 2) != 0);
      word = {$urandom, $urandom};
      checkValue("rnd_count", 64'(oCount), 64'(sb.size()));
      if (oData_valid && rd) begin
        exp = sb.pop_front();
        checkValue("rnd_data", oData, exp);
      end
      if (wr) begin
        sb.push_back(word);
        pushes++;
      end
      iWrite_request = wr;
      iData = word;
      iData_ready = rd;
      tick();
      cycles++;
    end
    checkValue("rnd_push_budget", 64'(pushes), 64'd1000);
    iWrite_request = 1'b0;
    iData_ready = 1'b1;
    cycles = 0;
    while (sb.size() != 0 && cycles < 100) begin
      if (oData_valid) begin
        exp = sb.pop_front();
        checkValue("rnd_drain_data", oData, exp);
      end
      tick();
      cycles++;
    end
    checkValue("rnd_drain_left", 64'(sb.size()), 64'd0);
    checkValue("rnd_ovf", 64'(oOverflow), 64'd0);
    checkValue("rnd_empty", 64'(oEmpty), 64'd1);
    iData_ready = 1'b0;

    // Reset mid-operation at count 10, with a push presented during reset
    for (int i = 0; i < 10; i++) begin
      iWrite_request = 1'b1;
      iData = 64'(400 + i);
      tick();
    end
    checkValue("mid_count10", 64'(oCount), 64'd10);
    iReset_n = 1'b0;
    iData = 64'd777;
    tick();
    iReset_n = 1'b1;
    iWrite_request = 1'b0;
    checkValue("mid_rst_count", 64'(oCount), 64'd0);
    checkValue("mid_rst_empty", 64'(oEmpty), 64'd1);
    checkValue("mid_rst_valid", 64'(oData_valid), 64'd0);
    checkValue("mid_rst_ovf", 64'(oOverflow), 64'd0);
    checkValue("mid_rst_data", oData, 64'd0);
    iWrite_request = 1'b1;
    iData = 64'hABCD;
    tick();
    iWrite_request = 1'b0;
    checkValue("post_rst_valid", 64'(oData_valid), 64'd1);
    checkValue("post_rst_data", oData, 64'hABCD);
    checkValue("post_rst_count", 64'(oCount), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
